clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
- Upstream stage of the 4-digit multiplexed 7-segment `led` driver.
- Keeps 24-hour time as HH:MM and presents it as four BCD digits on `numcount4_out..numcount1_out`. Those ports connect one-to-one to the driver's same-named inputs.
- Advances once per second from a prescaled system clock.
- Has a two-button time-set mode (MODE / INC).

Parameters:
- CLK_HZ, 1000, system clock frequency in Hz. Must be ≥ 2. The 1 kHz default matches the display subsystem clock.
- SEC_PER_MIN, 60, seconds per minute rollover. Benches may reduce it for short simulations; must be ≥ 1.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst_n, input, 1, reset, synchronous and active-low.
- key_mode, input, 1, MODE button level, active-high, already debounced, asynchronous to clk.
- key_inc, input, 1, INC button level, active-high, already debounced, asynchronous to clk.
- numcount4_out, output, 4, hour tens BCD (0–2).
- numcount3_out, output, 4, hour units BCD (0–9; 0–3 when tens = 2).
- numcount2_out, output, 4, minute tens BCD (0–5).
- numcount1_out, output, 4, minute units BCD (0–9).
- sec_tick, output, 1, one-cycle pulse on each 1 Hz prescaler wrap.
- set_mode, output, 2, state: 0 RUN, 1 SET_HOUR, 2 SET_MIN.
- blink, output, 1, toggles on each sec_tick while set_mode ≠ 0; held 0 in RUN.

Behaviour:
- Reset (rst_n = 0 at a clk edge): all of the following clear to 0 / 00:00.
  - Outputs: digits 00:00, sec_tick, set_mode = RUN, blink.
  - Internal state: prescaler, seconds counter, synchronizer flops, edge-detect flops.
  - Reset takes priority over every other event in the same cycle, including mid-set.
- Prescaler:
  - Counts 0..CLK_HZ−1 and wraps.
  - sec_tick = 1 in the cycle the counter holds CLK_HZ−1, so there is exactly one pulse per CLK_HZ cycles.
  - First pulse occurs CLK_HZ cycles after reset release.
  - Runs in all states.
- Key input path:
  - Each key passes through a 2-flop synchronizer, then rising-edge detection against a third flop.
  - The resulting press pulse is 1 cycle wide, 3 cycles after the input rises.
  - Holding a key produces only one pulse.
- State machine:
  - RUN, on MODE pulse → SET_HOUR.
  - SET_HOUR, on MODE pulse → SET_MIN.
  - SET_MIN, on MODE pulse → RUN.
  - No other transitions.
- RUN behaviour, on each sec_tick:
  - Seconds counter (0..SEC_PER_MIN−1) increments.
  - On wrap to 0, minutes increment.
  - Minute units 9 → 0 with carry into tens; 59 → 00 with carry into hours.
  - Hours: units 9 → 0 with carry into tens; 23 → 00.
  - An INC pulse in RUN is ignored.
- SET_HOUR behaviour:
  - Time does not advance from sec_tick; the seconds counter holds.
  - INC pulse: hours +1 BCD, 23 → 00. Minutes unchanged, no carry.
- SET_MIN behaviour:
  - Time does not advance from sec_tick; the seconds counter holds.
  - INC pulse: minutes +1 BCD, 59 → 00. Hours unchanged, no carry.
  - The seconds counter clears to 0 on the MODE pulse that leaves SET_MIN, so RUN restarts at :00 seconds.
- Simultaneous events:
  - MODE and INC pulses in the same cycle: MODE wins and INC is dropped.
  - sec_tick coinciding with a MODE pulse from RUN: the tick is applied first, then the state changes (carry completes).
- Update timing: digit outputs are registered and update the cycle after the causing event. No combinational path from keys to outputs.
- Invariant: digits are always valid BCD within the ranges listed in Ports. Any illegal value (not reachable) forces 00:00 on the next edge.

Test Plan:
- Reset then run (CLK_HZ = 4, SEC_PER_MIN = 2): rst_n low 3 cycles, release.
  - Digits read 0,0,0,0.
  - First sec_tick after 4 cycles.
  - After 8 cycles, numcount1_out = 1.
- Minute/hour rollover: force time to 09:59 via set mode, return to RUN, wait one minute → 10:00. From 23:59, wait one minute → 00:00.
- Set hours: MODE once (set_mode = 1).
  - INC 25 times from 00:xx → hours = 01, minutes unchanged.
  - blink toggles on each sec_tick.
  - Time frozen across ≥ 3 ticks.
- Set minutes: MODE twice, INC 61 times from hh:00 → minutes = 01, hours unchanged. MODE → RUN, set_mode = 0, blink = 0, seconds restart at 0.
- Edge/sync: hold key_inc high 20 cycles → exactly one increment, appearing 4 cycles after the rise. MODE and INC rising in the same cycle → state advances, no increment.
- Mid-set reset: in SET_MIN at 12:34, assert rst_n low 1 cycle → 00:00, set_mode = 0, blink = 0 on the next edge.

Source files
------------

// File: rtl/clock_time_counter.sv
// clock_time_counter: 24-hour HH:MM clock feeding the 4-digit 7-segment driver.
// A prescaler divides clk down to a 1 Hz sec_tick. Two debounced buttons
// (MODE / INC) step through RUN -> SET_HOUR -> SET_MIN and adjust the time.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   key_mode       MODE button level (async to clk)
//   key_inc        INC button level (async to clk)
//   numcount4_out  hour tens BCD
//   numcount3_out  hour units BCD
//   numcount2_out  minute tens BCD
//   numcount1_out  minute units BCD
//   sec_tick       one-cycle pulse per CLK_HZ cycles
//   set_mode       0 RUN, 1 SET_HOUR, 2 SET_MIN
//   blink          toggles on sec_tick while setting, 0 in RUN
module clock_time_counter #(
    parameter int unsigned CLK_HZ      = 1000,
    parameter int unsigned SEC_PER_MIN = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] numcount4_out,
    output logic [3:0] numcount3_out,
    output logic [3:0] numcount2_out,
    output logic [3:0] numcount1_out,
    output logic       sec_tick,
    output logic [1:0] set_mode,
    output logic       blink
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned SW = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_PRE  = PW'(CLK_HZ - 2);
    localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_PER_MIN - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    logic [SW-1:0] r_sec;
    logic [SW-1:0] w_sec_nxt;
    logic [3:0]    r_h10, r_h1, r_m10, r_m1;
    logic [3:0]    w_h10_nxt, w_h1_nxt, w_m10_nxt, w_m1_nxt;
    logic [3:0]    w_h10_inc, w_h1_inc, w_m10_inc, w_m1_inc;
    logic          w_min_carry;
    logic          w_bad;
    logic          r_blink;
    logic          r_mode_s1, r_mode_s2, r_mode_s3, r_mode_p;
    logic          r_inc_s1, r_inc_s2, r_inc_s3, r_inc_p;

    // Prescaler; the tick is registered so it is high exactly while the count holds CLK_HZ-1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_sec_tick <= 1'b0;
        end else begin
            r_presc    <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
            r_sec_tick <= (r_presc == PRESC_PRE);
        end
    end

    // Two-flop synchronizers, third flop for edge detect, registered one-cycle press pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
            r_mode_s3 <= 1'b0;
            r_mode_p  <= 1'b0;
            r_inc_s1  <= 1'b0;
            r_inc_s2  <= 1'b0;
            r_inc_s3  <= 1'b0;
            r_inc_p   <= 1'b0;
        end else begin
            r_mode_s1 <= key_mode;
            r_mode_s2 <= r_mode_s1;
            r_mode_s3 <= r_mode_s2;
            r_mode_p  <= r_mode_s2 & ~r_mode_s3;
            r_inc_s1  <= key_inc;
            r_inc_s2  <= r_inc_s1;
            r_inc_s3  <= r_inc_s2;
            r_inc_p   <= r_inc_s2 & ~r_inc_s3;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_state_nxt;
    end

    // Next state: MODE cycles RUN -> SET_HOUR -> SET_MIN -> RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (r_mode_p) w_state_nxt = ST_SET_HOUR;
            ST_SET_HOUR: if (r_mode_p) w_state_nxt = ST_SET_MIN;
            ST_SET_MIN:  if (r_mode_p) w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    // BCD +1 candidates for minutes (with carry-out) and hours (23 -> 00)
    always_comb begin
        w_m1_inc    = r_m1 + 4'd1;
        w_m10_inc   = r_m10;
        w_min_carry = 1'b0;
        if (r_m1 == 4'd9) begin
            w_m1_inc = 4'd0;
            if (r_m10 == 4'd5) begin
                w_m10_inc   = 4'd0;
                w_min_carry = 1'b1;
            end else begin
                w_m10_inc = r_m10 + 4'd1;
            end
        end

        w_h1_inc  = r_h1 + 4'd1;
        w_h10_inc = r_h10;
        if (r_h10 == 4'd2 && r_h1 == 4'd3) begin
            w_h1_inc  = 4'd0;
            w_h10_inc = 4'd0;
        end else if (r_h1 == 4'd9) begin
            w_h1_inc  = 4'd0;
            w_h10_inc = r_h10 + 4'd1;
        end
    end

    // Time next-state: advance in RUN, manual adjust in the set states
    always_comb begin
        w_h10_nxt = r_h10;
        w_h1_nxt  = r_h1;
        w_m10_nxt = r_m10;
        w_m1_nxt  = r_m1;
        w_sec_nxt = r_sec;
        w_bad     = (r_h10 > 4'd2) || (r_h1 > 4'd9) ||
                    (r_h10 == 4'd2 && r_h1 > 4'd3) ||
                    (r_m10 > 4'd5) || (r_m1 > 4'd9);
        if (w_bad) begin
            // unreachable corruption recovery
            w_h10_nxt = 4'd0;
            w_h1_nxt  = 4'd0;
            w_m10_nxt = 4'd0;
            w_m1_nxt  = 4'd0;
            w_sec_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // a MODE pulse here only changes state; the tick still completes
                    if (r_sec_tick) begin
                        if (r_sec == SEC_LAST) begin
                            w_sec_nxt = '0;
                            w_m10_nxt = w_m10_inc;
                            w_m1_nxt  = w_m1_inc;
                            if (w_min_carry) begin
                                w_h10_nxt = w_h10_inc;
                                w_h1_nxt  = w_h1_inc;
                            end
                        end else begin
                            w_sec_nxt = r_sec + SW'(1);
                        end
                    end
                end
                ST_SET_HOUR: begin
                    if (r_inc_p && !r_mode_p) begin
                        w_h10_nxt = w_h10_inc;
                        w_h1_nxt  = w_h1_inc;
                    end
                end
                ST_SET_MIN: begin
                    // leaving SET_MIN restarts the minute at :00
                    if (r_mode_p) begin
                        w_sec_nxt = '0;
                    end else if (r_inc_p) begin
                        w_m10_nxt = w_m10_inc;
                        w_m1_nxt  = w_m1_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Time and seconds registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h10 <= 4'd0;
            r_h1  <= 4'd0;
            r_m10 <= 4'd0;
            r_m1  <= 4'd0;
            r_sec <= '0;
        end else begin
            r_h10 <= w_h10_nxt;
            r_h1  <= w_h1_nxt;
            r_m10 <= w_m10_nxt;
            r_m1  <= w_m1_nxt;
            r_sec <= w_sec_nxt;
        end
    end

    // Blink: toggles on ticks only while staying in a set state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink <= 1'b0;
        end else if (r_state == ST_RUN || w_state_nxt == ST_RUN) begin
            r_blink <= 1'b0;
        end else if (r_sec_tick) begin
            r_blink <= ~r_blink;
        end
    end

    assign numcount4_out = r_h10;
    assign numcount3_out = r_h1;
    assign numcount2_out = r_m10;
    assign numcount1_out = r_m1;
    assign sec_tick      = r_sec_tick;
    assign set_mode      = r_state;
    assign blink         = r_blink;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter with CLK_HZ = 4, SEC_PER_MIN = 2.
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_clock_time_counter;

    localparam int unsigned CLK_HZ      = 4;
    localparam int unsigned SEC_PER_MIN = 2;

    localparam logic [3:0] EN_DIG  = 4'b0001;
    localparam logic [3:0] EN_MODE = 4'b0010;
    localparam logic [3:0] EN_BLK  = 4'b0100;
    localparam logic [3:0] EN_TCK  = 4'b1000;

    typedef struct packed {
        logic [3:0]  en;
        logic [15:0] dig;
        logic [1:0]  mode;
        logic        blink;
        logic        tick;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode;
    logic       key_inc;
    logic [3:0] numcount4_out, numcount3_out, numcount2_out, numcount1_out;
    logic       sec_tick;
    logic [1:0] set_mode;
    logic       blink;

    exp_t  q[$];
    string qn[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    exp_t        m_e;
    string       m_nm;
    logic [15:0] m_dig;

    always #5 clk = ~clk;

    clock_time_counter #(
        .CLK_HZ      (CLK_HZ),
        .SEC_PER_MIN (SEC_PER_MIN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_mode      (key_mode),
        .key_inc       (key_inc),
        .numcount4_out (numcount4_out),
        .numcount3_out (numcount3_out),
        .numcount2_out (numcount2_out),
        .numcount1_out (numcount1_out),
        .sec_tick      (sec_tick),
        .set_mode      (set_mode),
        .blink         (blink)
    );

    // Monitor: compare every queued expectation on the falling edge
    always @(negedge clk) begin
        while (q.size() != 0) begin
            m_e   = q.pop_front();
            m_nm  = qn.pop_front();
            m_dig = {numcount4_out, numcount3_out, numcount2_out, numcount1_out};
            if (m_e.en[0]) begin
                n_cmp++;
                if (m_dig !== m_e.dig) begin
                    n_bad++;
                    $display("FAIL %s digits: got %h want %h", m_nm, m_dig, m_e.dig);
                end
            end
            if (m_e.en[1]) begin
                n_cmp++;
                if (set_mode !== m_e.mode) begin
                    n_bad++;
                    $display("FAIL %s set_mode: got %0d want %0d", m_nm, set_mode, m_e.mode);
                end
            end
            if (m_e.en[2]) begin
                n_cmp++;
                if (blink !== m_e.blink) begin
                    n_bad++;
                    $display("FAIL %s blink: got %b want %b", m_nm, blink, m_e.blink);
                end
            end
            if (m_e.en[3]) begin
                n_cmp++;
                if (sec_tick !== m_e.tick) begin
                    n_bad++;
                    $display("FAIL %s sec_tick: got %b want %b", m_nm, sec_tick, m_e.tick);
                end
            end
        end
    end

    task automatic expect_out(input string name, input logic [3:0] en, input logic [15:0] dig,
                              input logic [1:0] mode, input logic bl, input logic tk);
        exp_t e;
        e.en    = en;
        e.dig   = dig;
        e.mode  = mode;
        e.blink = bl;
        e.tick  = tk;
        q.push_back(e);
        qn.push_back(name);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press pulse lands on the 4th edge after the rise; task returns just after it
    task automatic press(input logic m, input logic i);
        key_mode = m;
        key_inc  = i;
        step(2);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        step(2);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic inc_n(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset, then free-run
        do_reset();
        expect_out("reset", EN_DIG | EN_MODE | EN_BLK | EN_TCK, 16'h0000, 2'd0, 1'b0, 1'b0);
        step(2);
        expect_out("no_tick_e2", EN_TCK, 16'h0000, 2'd0, 1'b0, 1'b0);
        step(1);
        expect_out("first_tick", EN_DIG | EN_TCK, 16'h0000, 2'd0, 1'b0, 1'b1);
        step(1);
        expect_out("tick_gone", EN_DIG | EN_TCK, 16'h0000, 2'd0, 1'b0, 1'b0);
        step(3);
        expect_out("second_tick", EN_DIG | EN_TCK, 16'h0000, 2'd0, 1'b0, 1'b1);
        step(1);
        expect_out("one_minute", EN_DIG, 16'h0001, 2'd0, 1'b0, 1'b0);

        // Set hours: frozen time, blink toggles per tick, 25 increments
        do_reset();
        press(1'b1, 1'b0);
        expect_out("enter_sethr", EN_DIG | EN_MODE | EN_BLK, 16'h0000, 2'd1, 1'b0, 1'b0);
        step(4);
        expect_out("blink1", EN_DIG | EN_BLK, 16'h0000, 2'd1, 1'b1, 1'b0);
        step(4);
        expect_out("blink2", EN_DIG | EN_BLK, 16'h0000, 2'd1, 1'b0, 1'b0);
        step(4);
        expect_out("blink3", EN_DIG | EN_BLK | EN_MODE, 16'h0000, 2'd1, 1'b1, 1'b0);
        for (int i = 1; i <= 25; i++) begin
            press(1'b0, 1'b1);
            case (i)
                9:  expect_out("hr_9",  EN_DIG, 16'h0900, 2'd1, 1'b0, 1'b0);
                10: expect_out("hr_10", EN_DIG, 16'h1000, 2'd1, 1'b0, 1'b0);
                20: expect_out("hr_20", EN_DIG, 16'h2000, 2'd1, 1'b0, 1'b0);
                23: expect_out("hr_23", EN_DIG, 16'h2300, 2'd1, 1'b0, 1'b0);
                24: expect_out("hr_wrap", EN_DIG, 16'h0000, 2'd1, 1'b0, 1'b0);
                25: expect_out("hr_25", EN_DIG | EN_MODE, 16'h0100, 2'd1, 1'b0, 1'b0);
                default: ;
            endcase
        end

        // Set minutes: 61 increments, then back to RUN with seconds cleared
        press(1'b1, 1'b0);
        expect_out("enter_setmin", EN_DIG | EN_MODE, 16'h0100, 2'd2, 1'b0, 1'b0);
        for (int i = 1; i <= 61; i++) begin
            press(1'b0, 1'b1);
            case (i)
                9:  expect_out("min_9",  EN_DIG, 16'h0109, 2'd2, 1'b0, 1'b0);
                10: expect_out("min_10", EN_DIG, 16'h0110, 2'd2, 1'b0, 1'b0);
                59: expect_out("min_59", EN_DIG, 16'h0159, 2'd2, 1'b0, 1'b0);
                60: expect_out("min_wrap", EN_DIG, 16'h0100, 2'd2, 1'b0, 1'b0);
                61: expect_out("min_61", EN_DIG, 16'h0101, 2'd2, 1'b0, 1'b0);
                default: ;
            endcase
        end
        press(1'b1, 1'b0);
        expect_out("back_run", EN_DIG | EN_MODE | EN_BLK, 16'h0101, 2'd0, 1'b0, 1'b0);
        step(4);
        expect_out("sec_restart", EN_DIG | EN_BLK, 16'h0101, 2'd0, 1'b0, 1'b0);
        step(4);
        expect_out("run_after_set", EN_DIG, 16'h0102, 2'd0, 1'b0, 1'b0);

        // Rollovers: 09:59 -> 10:00 and 23:59 -> 00:00
        do_reset();
        press(1'b1, 1'b0);
        inc_n(9);
        press(1'b1, 1'b0);
        inc_n(59);
        press(1'b1, 1'b0);
        expect_out("at_0959", EN_DIG | EN_MODE, 16'h0959, 2'd0, 1'b0, 1'b0);
        step(4);
        expect_out("hold_0959", EN_DIG, 16'h0959, 2'd0, 1'b0, 1'b0);
        step(4);
        expect_out("roll_1000", EN_DIG, 16'h1000, 2'd0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        inc_n(13);
        press(1'b1, 1'b0);
        inc_n(59);
        press(1'b1, 1'b0);
        expect_out("at_2359", EN_DIG | EN_MODE, 16'h2359, 2'd0, 1'b0, 1'b0);
        step(4);
        expect_out("hold_2359", EN_DIG, 16'h2359, 2'd0, 1'b0, 1'b0);
        step(4);
        expect_out("roll_0000", EN_DIG | EN_MODE, 16'h0000, 2'd0, 1'b0, 1'b0);

        // Key path: INC ignored in RUN, tick+MODE, held key, MODE+INC together
        do_reset();
        press(1'b0, 1'b1);
        expect_out("run_inc_ignored", EN_DIG | EN_MODE, 16'h0000, 2'd0, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        expect_out("tick_then_mode", EN_DIG | EN_MODE, 16'h0001, 2'd1, 1'b0, 1'b0);
        key_inc = 1'b1;
        step(3);
        expect_out("hold_pre", EN_DIG, 16'h0001, 2'd1, 1'b0, 1'b0);
        step(1);
        expect_out("hold_inc", EN_DIG, 16'h0101, 2'd1, 1'b0, 1'b0);
        step(16);
        key_inc = 1'b0;
        expect_out("hold_once", EN_DIG, 16'h0101, 2'd1, 1'b0, 1'b0);
        step(4);
        expect_out("release_once", EN_DIG, 16'h0101, 2'd1, 1'b0, 1'b0);
        press(1'b1, 1'b1);
        expect_out("mode_wins", EN_DIG | EN_MODE, 16'h0101, 2'd2, 1'b0, 1'b0);

        // Reset in the middle of SET_MIN at 12:34
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        inc_n(11);
        press(1'b1, 1'b0);
        inc_n(33);
        expect_out("at_1234", EN_DIG | EN_MODE, 16'h1234, 2'd2, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1);
        expect_out("midset_reset", EN_DIG | EN_MODE | EN_BLK | EN_TCK, 16'h0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        step(3);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
